game_flow_ctrl: RTL and testbench

Top-level game sequencer for the maze game. Holds the screen/stage state consumed by the map renderer and sprite logic, detects button presses, runs the per-stage countdown, and decides SUCCESS/FAIL from the key count, exit and collision flags supplied by the player logic. Sits between the debounced button inputs and every renderer/player block that is keyed on `state`.

---
 rtl/game_flow_ctrl.sv | 136 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Maze game sequencer: title/staff screens, three timed stages with success
// screens, fail screen, button edge detection and per-stage countdown.
module game_flow_ctrl #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned STAGE_TIME = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_staff,
  input  logic [1:0] key_find,
  input  logic       at_exit,
  input  logic       caught,
  output logic [3:0] state,
  output logic [6:0] time_left,
  output logic       stage_start,
  output logic       stage_clear
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [6:0] TIME_LOAD = 7'(STAGE_TIME);

  localparam logic [3:0] S_TITLE    = 4'd0;
  localparam logic [3:0] S_STAFF    = 4'd1;
  localparam logic [3:0] S_STAGE1   = 4'd2;
  localparam logic [3:0] S_SUCCESS1 = 4'd3;
  localparam logic [3:0] S_STAGE2   = 4'd4;
  localparam logic [3:0] S_SUCCESS2 = 4'd5;
  localparam logic [3:0] S_STAGE3   = 4'd6;
  localparam logic [3:0] S_SUCCESS3 = 4'd7;
  localparam logic [3:0] S_FAIL     = 4'd8;

  logic [3:0]       r_state;
  logic             r_start_q;
  logic             r_staff_q;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [6:0]       r_time_left;
  logic             r_stage_start;
  logic             r_stage_clear;

  logic             w_start_evt;
  logic             w_staff_evt;
  logic             w_in_stage;
  logic             w_tick;
  logic             w_timeout;
  logic             w_success;
  logic [3:0]       w_next_state;
  logic             w_state_chg;
  logic             w_next_is_stage;
  logic             w_next_is_succ;
  logic [CNT_W-1:0] w_tick_cnt_nxt;
  logic [6:0]       w_time_left_nxt;
  logic             w_stage_start_nxt;
  logic             w_stage_clear_nxt;

  assign w_start_evt = btn_start & ~r_start_q;
  assign w_staff_evt = btn_staff & ~r_staff_q;
  assign w_in_stage  = (r_state == S_STAGE1) || (r_state == S_STAGE2) ||
                       (r_state == S_STAGE3);
  assign w_tick      = w_in_stage && (r_tick_cnt == TICK_LAST);
  assign w_timeout   = w_tick && (r_time_left == 7'd1);
  assign w_success   = at_exit && (key_find == 2'b11);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_TITLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; within a stage, a hazard or timeout beats reaching the exit
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_TITLE: begin
        if (w_start_evt)      w_next_state = S_STAGE1;
        else if (w_staff_evt) w_next_state = S_STAFF;
      end
      S_STAFF:    if (w_start_evt || w_staff_evt) w_next_state = S_TITLE;
      S_STAGE1, S_STAGE2, S_STAGE3: begin
        if (caught || w_timeout) w_next_state = S_FAIL;
        else if (w_success)      w_next_state = r_state + 4'd1;
      end
      S_SUCCESS1: if (w_start_evt) w_next_state = S_STAGE2;
      S_SUCCESS2: if (w_start_evt) w_next_state = S_STAGE3;
      S_SUCCESS3: if (w_start_evt) w_next_state = S_TITLE;
      S_FAIL:     if (w_start_evt) w_next_state = S_TITLE;
      default:    w_next_state = S_TITLE;
    endcase
  end

  // Next values of the tick counter, countdown and entry pulses
  always_comb begin
    w_state_chg       = (w_next_state != r_state);
    w_next_is_stage   = (w_next_state == S_STAGE1) || (w_next_state == S_STAGE2) ||
                        (w_next_state == S_STAGE3);
    w_next_is_succ    = (w_next_state == S_SUCCESS1) || (w_next_state == S_SUCCESS2) ||
                        (w_next_state == S_SUCCESS3);
    w_tick_cnt_nxt    = r_tick_cnt;
    w_time_left_nxt   = r_time_left;
    w_stage_start_nxt = w_state_chg && w_next_is_stage;
    w_stage_clear_nxt = w_state_chg && w_next_is_succ;

    if (w_state_chg)     w_tick_cnt_nxt = '0;
    else if (w_tick)     w_tick_cnt_nxt = '0;
    else if (w_in_stage) w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);

    if (w_state_chg && w_next_is_stage) w_time_left_nxt = TIME_LOAD;
    else if (w_tick)                    w_time_left_nxt = r_time_left - 7'd1;
  end

  // Datapath registers; button history resets high so a held button is not an event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q     <= 1'b1;
      r_staff_q     <= 1'b1;
      r_tick_cnt    <= '0;
      r_time_left   <= 7'd0;
      r_stage_start <= 1'b0;
      r_stage_clear <= 1'b0;
    end else begin
      r_start_q     <= btn_start;
      r_staff_q     <= btn_staff;
      r_tick_cnt    <= w_tick_cnt_nxt;
      r_time_left   <= w_time_left_nxt;
      r_stage_start <= w_stage_start_nxt;
      r_stage_clear <= w_stage_clear_nxt;
    end
  end

  assign state       = r_state;
  assign time_left   = r_time_left;
  assign stage_start = r_stage_start;
  assign stage_clear = r_stage_clear;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: screen-level model checked every cycle plus
// directed literal expectations along the play-through scenarios.
module tb_game_flow_ctrl;

  localparam int TB_TICK = 4;
  localparam int TB_TIME = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b1;
  logic       btn_staff = 1'b0;
  logic [1:0] key_find = 2'b00;
  logic       at_exit = 1'b0;
  logic       caught = 1'b0;
  logic [3:0] state;
  logic [6:0] time_left;
  logic       stage_start;
  logic       stage_clear;

  int n_checks = 0;
  int n_errors = 0;

  game_flow_ctrl #(.TICK_DIV(TB_TICK), .STAGE_TIME(TB_TIME)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_staff(btn_staff),
    .key_find(key_find), .at_exit(at_exit), .caught(caught), .state(state),
    .time_left(time_left), .stage_start(stage_start), .stage_clear(stage_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Screen-level model: stage n is screen 2n, its success screen 2n+1;
  // time left follows from the number of cycles spent in the stage.
  int m_state, m_time, m_elapsed, m_nxt;
  bit m_ps, m_pf, m_ss, m_sc, m_sevt, m_fevt;

  function automatic bit is_stage(input int s);
    return (s == 2) || (s == 4) || (s == 6);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_time = 0; m_elapsed = 0;
      m_ps = 1'b1; m_pf = 1'b1; m_ss = 1'b0; m_sc = 1'b0;
    end else begin
      m_sevt = btn_start && !m_ps;
      m_fevt = btn_staff && !m_pf;
      m_nxt  = m_state;
      if (m_state == 0) begin
        if (m_sevt) m_nxt = 2;
        else if (m_fevt) m_nxt = 1;
      end else if (m_state == 1) begin
        if (m_sevt || m_fevt) m_nxt = 0;
      end else if (is_stage(m_state)) begin
        m_elapsed = m_elapsed + 1;
        m_time = TB_TIME - m_elapsed / TB_TICK;
        if (caught || m_time == 0) m_nxt = 8;
        else if (at_exit && key_find == 2'b11) m_nxt = m_state + 1;
      end else if (m_state == 3 || m_state == 5) begin
        if (m_sevt) m_nxt = m_state + 1;
      end else if (m_state == 7 || m_state == 8) begin
        if (m_sevt) m_nxt = 0;
      end else begin
        m_nxt = 0;
      end
      m_ss = (m_nxt != m_state) && is_stage(m_nxt);
      m_sc = (m_nxt != m_state) && (m_nxt == 3 || m_nxt == 5 || m_nxt == 7);
      if (m_ss) begin
        m_time = TB_TIME;
        m_elapsed = 0;
      end
      m_state = m_nxt;
      m_ps = btn_start;
      m_pf = btn_staff;
    end
  end

  // Per-cycle comparison against the model, just after each active edge
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("model_state", int'(state), m_state);
      chk("model_time_left", int'(time_left), m_time);
      chk("model_stage_start", int'(stage_start), int'(m_ss));
      chk("model_stage_clear", int'(stage_clear), int'(m_sc));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start();
    btn_start = 1'b1; step(1); btn_start = 1'b0;
  endtask

  task automatic press_staff();
    btn_staff = 1'b1; step(1); btn_staff = 1'b0;
  endtask

  task automatic clear_stage();
    at_exit = 1'b1; key_find = 2'b11; step(1);
    at_exit = 1'b0; key_find = 2'b00;
  endtask

  initial begin
    // Start button held through reset release: no event
    step(3);
    rst_n = 1'b1;
    step(10);
    chk("held_btn_state", int'(state), 0);
    chk("held_btn_time", int'(time_left), 0);
    btn_start = 1'b0; step(1);
    press_start();
    chk("entry_state", int'(state), 2);
    chk("entry_stage_start", int'(stage_start), 1);
    chk("entry_time", int'(time_left), TB_TIME);
    step(1);
    chk("entry_pulse_len", int'(stage_start), 0);

    // Countdown: 3 -> 2 -> 1 every 4 cycles, FAIL 12 cycles after entry
    step(2);
    chk("cd_before_tick", int'(time_left), 3);
    step(1);
    chk("cd_first_tick", int'(time_left), 2);
    step(7);
    chk("cd_last_second", int'(time_left), 1);
    chk("cd_still_stage", int'(state), 2);
    step(1);
    chk("cd_timeout_state", int'(state), 8);
    chk("cd_timeout_time", int'(time_left), 0);
    step(2);
    chk("fail_holds", int'(state), 8);
    press_start();
    chk("fail_to_title", int'(state), 0);

    // Staff screen toggling and start priority
    press_staff();
    chk("staff_enter", int'(state), 1);
    step(1);
    press_staff();
    chk("staff_leave", int'(state), 0);
    step(1);
    btn_start = 1'b1; btn_staff = 1'b1; step(1);
    btn_start = 1'b0; btn_staff = 1'b0;
    chk("both_btn_start_wins", int'(state), 2);

    // Full run: exit without all keys is ignored
    key_find = 2'b01; at_exit = 1'b1; step(2);
    chk("exit_no_keys", int'(state), 2);
    key_find = 2'b11; step(1);
    at_exit = 1'b0; key_find = 2'b00;
    chk("success1_state", int'(state), 3);
    chk("success1_pulse", int'(stage_clear), 1);
    step(1);
    chk("success1_pulse_len", int'(stage_clear), 0);
    press_start();
    chk("stage2_state", int'(state), 4);
    chk("stage2_time", int'(time_left), TB_TIME);
    clear_stage();
    chk("success2_state", int'(state), 5);
    press_start();
    chk("stage3_state", int'(state), 6);
    clear_stage();
    chk("success3_state", int'(state), 7);
    press_start();
    chk("run_to_title", int'(state), 0);

    // Hazard alone ends the stage
    step(1);
    press_start();
    caught = 1'b1; step(1); caught = 1'b0;
    chk("caught_fail", int'(state), 8);
    press_start();

    // Caught, timeout and success on one edge: FAIL wins
    step(1);
    press_start();
    clear_stage();
    press_start();
    chk("prio_stage2", int'(state), 4);
    step(11);
    chk("prio_time_one", int'(time_left), 1);
    caught = 1'b1; at_exit = 1'b1; key_find = 2'b11; step(1);
    caught = 1'b0; at_exit = 1'b0; key_find = 2'b00;
    chk("prio_fail_state", int'(state), 8);
    chk("prio_fail_time", int'(time_left), 0);
    press_start();

    // Async reset right after entering stage 3
    step(1);
    press_start(); clear_stage(); press_start(); clear_stage(); press_start();
    chk("rst_pre_stage3", int'(state), 6);
    chk("rst_pre_pulse", int'(stage_start), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_time", int'(time_left), 0);
    chk("rst_stage_start", int'(stage_start), 0);
    chk("rst_stage_clear", int'(stage_clear), 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_title", int'(state), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
